shift_sequencer: RTL and testbench

Multi-cycle shift controller for the ALU datapath. It accepts a 32-bit operand and a 5-bit shift amount through a start/done handshake, then sequences a bounded-step shifter over several clock cycles until the full amount has been applied. Supported shifts are logical left, logical right and arithmetic right. It sits between the ALU control FSM and the shift datapath, so a full 0–31 shift never needs a single wide barrel stage.

---
 rtl/shift_sequencer_pkg.sv | 23 ++
 rtl/shift_sequencer_step.sv | 47 ++++
 rtl/shift_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the multi-cycle shift sequencer:
//   - FSM state encoding (IDLE / SHIFT / DONE, 2-bit)
//   - default shift-amount width for a 32-bit operand
//   - direction constants
// No ports; imported by shift_sequencer and shift_step.
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } seqState_t;

    // Shift-amount width for the default 32-bit operand.
    localparam int SHAMT_W = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational bounded shifter: moves dataIn by 0..STEP_MAX bit positions in
// one direction, filling vacated positions with fillBit. This is the only
// datapath element of the sequencer.
// Ports:
//   dataIn   in  WIDTH   operand for this step
//   step     in  STEP_W  positions to shift (0..STEP_MAX)
//   dir      in  1       0 = left, 1 = right
//   fillBit  in  1       value shifted into vacated positions
//   dataOut  out WIDTH   shifted result
// -----------------------------------------------------------------------------
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int STEP_MAX = 7,
    localparam int STEP_W   = $clog2(STEP_MAX + 1)
) (
    input  logic [WIDTH-1:0]  dataIn,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    input  logic              fillBit,
    output logic [WIDTH-1:0]  dataOut
);

    logic [2*WIDTH-1:0] ext_s;
    logic [2*WIDTH-1:0] shifted_s;

    // Shift a double-width word whose spare half is all fill bits, so vacated
    // positions are drawn from the fill half regardless of direction.
    always_comb begin
        ext_s     = '0;
        shifted_s = '0;
        dataOut   = dataIn;
        if (dir == DIR_RIGHT) begin
            ext_s     = {{WIDTH{fillBit}}, dataIn};
            shifted_s = ext_s >> step;
            dataOut   = shifted_s[WIDTH-1:0];
        end else begin
            ext_s     = {dataIn, {WIDTH{fillBit}}};
            shifted_s = ext_s << step;
            dataOut   = shifted_s[2*WIDTH-1:WIDTH];
        end
    end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle shift controller. Accepts an operand and a total shift amount on
// a start/done handshake and applies the shift in bounded steps of at most
// STEP_MAX positions per cycle (logical left, logical right, arithmetic right).
// Ports:
//   clk    in  1        rising-edge clock
//   rst    in  1        synchronous active-high reset
//   start  in  1        request, accepted only while idle and busy=0
//   in     in  WIDTH    operand, sampled on the accepting edge
//   shAmt  in  SW       total shift amount, sampled on the accepting edge
//   dir    in  1        0 = left, 1 = right, sampled on the accepting edge
//   arith  in  1        arithmetic fill (right shifts only)
//   busy   out 1        operation in progress
//   done   out 1        one-cycle pulse, out holds the result in that cycle
//   out    out WIDTH    working/result register
// All outputs are registered copies of the internal state, so they trail the
// FSM by one cycle: busy rises one edge after acceptance and done/out become
// final one edge after the last shift step.
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int STEP_MAX = 7,
    localparam int SW       = $clog2(WIDTH),
    localparam int STEP_W   = $clog2(STEP_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SW-1:0]    shAmt,
    input  logic             dir,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    seqState_t         state_r;
    logic [WIDTH-1:0]  work_r;
    logic [SW-1:0]     remaining_r;
    logic              fillBit_r;
    logic              dir_r;

    logic [STEP_W-1:0] step_s;
    logic [SW-1:0]     stepWide_s;
    logic [WIDTH-1:0]  stepResult_s;

    // Step size is derived only from the latched remaining count, never from
    // the live shAmt input, and is clamped to the per-cycle maximum.
    always_comb begin
        step_s = '0;
        if (remaining_r > SW'(STEP_MAX)) begin
            step_s = STEP_W'(STEP_MAX);
        end else begin
            step_s = remaining_r[STEP_W-1:0];
        end
        stepWide_s = SW'(step_s);
    end

    shift_step #(
        .WIDTH    (WIDTH),
        .STEP_MAX (STEP_MAX)
    ) u_shiftStep (
        .dataIn  (work_r),
        .step    (step_s),
        .dir     (dir_r),
        .fillBit (fillBit_r),
        .dataOut (stepResult_s)
    );

    // Sequencer FSM, working register, remaining counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            work_r      <= '0;
            remaining_r <= '0;
            fillBit_r   <= 1'b0;
            dir_r       <= DIR_LEFT;
            busy        <= 1'b0;
            done        <= 1'b0;
            out         <= '0;
        end else begin
            busy <= (state_r != S_IDLE);
            done <= (state_r == S_DONE);
            out  <= work_r;
            case (state_r)
                S_IDLE: begin
                    // busy still reflects the previous DONE cycle here, which
                    // keeps a start held through the done pulse from being taken.
                    if (start && !busy) begin
                        work_r      <= in;
                        remaining_r <= shAmt;
                        dir_r       <= dir;
                        // Left shifts always fill with zero, even when arith=1.
                        fillBit_r   <= dir & arith & in[WIDTH-1];
                        state_r     <= S_SHIFT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    work_r      <= stepResult_s;
                    remaining_r <= remaining_r - stepWide_s;
                    // A zero amount still takes one SHIFT cycle with step 0.
                    if (remaining_r == stepWide_s) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed-vector bench for shift_sequencer with hand-computed results,
// latencies and busy durations.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] inVal;
    logic [4:0]  shAmt;
    logic        dir;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(
        .WIDTH    (32),
        .STEP_MAX (7)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (inVal),
        .shAmt (shAmt),
        .dir   (dir),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs right after acceptance, then
    // measure cycles to done, busy cycles and the result.
    task automatic runOp(input string tag, input logic [31:0] val, input logic [4:0] amt,
                         input logic d, input logic a, input logic [31:0] expOut, input int expN);
        int  cyc;
        int  busyCyc;
        bit  seen;
        @(negedge clk);
        inVal = val; shAmt = amt; dir = d; arith = a; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; inVal = ~val; shAmt = ~amt; dir = ~d; arith = ~a;
        cyc = 0; busyCyc = 0; seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busyCyc++;
            if (done) seen = 1'b1;
        end
        checkVal({tag, "_doneSeen"}, 32'(seen), 32'd1);
        checkVal({tag, "_latency"}, 32'(cyc), 32'(expN + 1));
        checkVal({tag, "_busyCycles"}, 32'(busyCyc), 32'(expN + 1));
        checkVal({tag, "_out"}, out, expOut);
        @(posedge clk);
        #1;
        checkVal({tag, "_busyLow"}, 32'(busy), 32'd0);
        checkVal({tag, "_donePulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  doneCnt;
        bit  seen;

        rst = 1'b1; start = 1'b0; inVal = '0; shAmt = '0; dir = 1'b0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_busy", 32'(busy), 32'd0);
        checkVal("reset_done", 32'(done), 32'd0);
        checkVal("reset_out", out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Main function vectors: tag, in, shAmt, dir, arith, expected out, N.
        runOp("lsl3",      32'h0000000F, 5'd3,  1'b0, 1'b0, 32'h00000078, 1);
        runOp("asr31",     32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, 5);
        runOp("lsr4",      32'hF0000000, 5'd4,  1'b1, 1'b0, 32'h0F000000, 1);
        runOp("zero",      32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'hDEADBEEF, 1);
        runOp("lslArith",  32'hC0000001, 5'd1,  1'b0, 1'b1, 32'h80000002, 1);
        runOp("lsr7",      32'h80000000, 5'd7,  1'b1, 1'b0, 32'h01000000, 1);
        runOp("lsl8",      32'h00000001, 5'd8,  1'b0, 1'b0, 32'h00000100, 2);
        runOp("asr14",     32'h80000000, 5'd14, 1'b1, 1'b1, 32'hFFFE0000, 2);
        runOp("asrPos10",  32'h40000000, 5'd10, 1'b1, 1'b1, 32'h00100000, 2);
        runOp("lsr31",     32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001, 5);

        // out keeps the last result while idle.
        repeat (3) @(posedge clk);
        #1;
        checkVal("idleHold_out", out, 32'h00000001);

        // start during SHIFT with different operands is ignored.
        @(negedge clk);
        inVal = 32'h00000001; shAmt = 5'd31; dir = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        inVal = 32'h12345678; shAmt = 5'd2; dir = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checkVal("busyStart_doneSeen", 32'(seen), 32'd1);
        checkVal("busyStart_out", out, 32'h80000000);

        // start raised in the done cycle only must not be accepted.
        start = 1'b1; inVal = 32'hAAAA5555; shAmt = 5'd1; dir = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("doneCycleStart_busy", 32'(busy), 32'd0);
        checkVal("doneCycleStart_out", out, 32'h80000000);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        inVal = 32'h80000000; shAmt = 5'd31; dir = 1'b1; arith = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkVal("midReset_busy", 32'(busy), 32'd0);
        checkVal("midReset_out", out, 32'h0);
        checkVal("midReset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) doneCnt++;
        end
        checkVal("midReset_noDone", 32'(doneCnt), 32'd0);
        checkVal("midReset_idle", 32'(busy), 32'd0);

        // Normal operation resumes after the abort.
        runOp("afterReset", 32'h00000003, 5'd2, 1'b0, 1'b0, 32'h0000000C, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_sequencer
